// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared types and elaboration helpers for the parity stream accumulator
package parity_pkg;

    localparam int MAX_LANES = 32;

    typedef struct packed {
        logic                 last;
        logic                 odd;
        logic [MAX_LANES-1:0] exp;
    } sideband_t;

    function automatic int lane_w(input int data_w, input int lanes);
        return data_w / lanes;
    endfunction

    function automatic bit cfg_ok(input int data_w, input int lanes, input int pipe_stages);
        return (lanes > 0) && (lanes <= MAX_LANES) && (data_w % lanes == 0) &&
               (pipe_stages >= 0) && (pipe_stages <= 3);
    endfunction

endpackage

// File: rtl/parity_lane_tree.sv
// rtl/parity_lane_tree.sv - XOR reduce of one lane, retimed through PIPE_STAGES stall-enabled registers
module parity_lane_tree #(
    parameter int LANE_W      = 8,
    parameter int PIPE_STAGES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [LANE_W-1:0] lane,
    output logic              par
);

    logic red;
    assign red = ^lane;

    if (PIPE_STAGES == 0) begin : g_comb
        assign par = red;
    end else begin : g_pipe
        logic [PIPE_STAGES-1:0] q;
        // The reduction operator maps to a balanced tree; the stages retime it.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q <= '0;
            end else if (en) begin
                q <= (q << 1) | PIPE_STAGES'(red);
            end
        end
        assign par = q[PIPE_STAGES-1];
    end

endmodule

// File: rtl/parity_stream_accum.sv
// rtl/parity_stream_accum.sv - per-lane packet parity generator/checker over a valid/ready beat stream
module parity_stream_accum
    import parity_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int LANES       = 2,
    parameter int PIPE_STAGES = 1,
    parameter int BEAT_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              cfg_odd,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic [LANES-1:0]  in_exp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LANES-1:0]  out_par,
    output logic              out_err,
    output logic [BEAT_W-1:0] out_beats
);

    localparam int LW = lane_w(DATA_W, LANES);
    localparam logic [BEAT_W-1:0] BEAT_MAX = '1;

    if (!cfg_ok(DATA_W, LANES, PIPE_STAGES)) begin : g_bad_cfg
        $error("parity_stream_accum: DATA_W must divide into LANES and PIPE_STAGES must be 0..3");
    end

    logic             alive;
    logic             stall;
    logic             accept;
    logic             exit_fire;
    logic             x_vld;
    sideband_t        in_sb;
    sideband_t        x_sb;
    logic [LANES-1:0] x_p;
    logic [LANES-1:0] acc;
    logic [LANES-1:0] par_next;
    logic [BEAT_W-1:0] beats;
    logic [BEAT_W-1:0] beats_next;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = alive & ~stall;
    assign accept   = in_valid & in_ready & ~flush;
    assign in_sb    = '{last: in_last, odd: cfg_odd, exp: MAX_LANES'(in_exp)};

    // Lane 0 (in_data LSBs) reports on the MSB of out_par; in_exp uses the same order.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        parity_lane_tree #(.LANE_W(LW), .PIPE_STAGES(PIPE_STAGES)) u_tree (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (~stall),
            .lane  (in_data[k*LW +: LW]),
            .par   (x_p[LANES-1-k])
        );
    end

    if (PIPE_STAGES == 0) begin : g_sb_comb
        assign x_vld = accept;
        assign x_sb  = in_sb;
    end else begin : g_sb_pipe
        logic [PIPE_STAGES-1:0] vld;
        sideband_t              sb [PIPE_STAGES];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld <= '0;
                for (int i = 0; i < PIPE_STAGES; i++) sb[i] <= '0;
            end else begin
                if (flush) begin
                    vld <= '0;
                end else if (!stall) begin
                    vld <= (vld << 1) | PIPE_STAGES'(accept);
                end
                if (!stall) begin
                    sb[0] <= in_sb;
                    for (int i = 1; i < PIPE_STAGES; i++) sb[i] <= sb[i-1];
                end
            end
        end

        assign x_vld = vld[PIPE_STAGES-1];
        assign x_sb  = sb[PIPE_STAGES-1];
    end

    assign exit_fire  = x_vld & ~stall & ~flush;
    assign par_next   = acc ^ x_p ^ {LANES{x_sb.odd}};
    assign beats_next = (beats == BEAT_MAX) ? beats : beats + BEAT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive     <= 1'b0;
            acc       <= '0;
            beats     <= '0;
            out_valid <= 1'b0;
            out_par   <= '0;
            out_err   <= 1'b0;
            out_beats <= '0;
        end else begin
            alive <= 1'b1;
            // A new result at exit overrides the consume, keeping back-to-back packets at full rate.
            if (out_ready) out_valid <= 1'b0;
            if (flush) begin
                acc   <= '0;
                beats <= '0;
            end else if (exit_fire) begin
                if (x_sb.last) begin
                    acc       <= '0;
                    beats     <= '0;
                    out_valid <= 1'b1;
                    out_par   <= par_next;
                    out_err   <= |(MAX_LANES'(par_next) ^ x_sb.exp);
                    out_beats <= beats_next;
                end else begin
                    acc   <= acc ^ x_p;
                    beats <= beats_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_parity_stream_accum.sv
// tb/tb_parity_stream_accum.sv - randomized and directed bench for parity_stream_accum
module tb_parity_stream_accum;

    localparam int DATA_W      = 16;
    localparam int LANES       = 2;
    localparam int PIPE_STAGES = 1;
    localparam int BEAT_W      = 2;
    localparam int LW          = DATA_W / LANES;
    localparam int BMAX        = (1 << BEAT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              cfg_odd = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_last = 1'b0;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic [LANES-1:0]  in_exp = '0;
    logic              in_ready;
    logic              out_valid;
    logic              out_err;
    logic [LANES-1:0]  out_par;
    logic [BEAT_W-1:0] out_beats;

    typedef struct {
        logic [LANES-1:0] par;
        logic             err;
        int               beats;
    } result_t;

    int                checks = 0;
    int                errors = 0;
    int                ready_pct = 100;
    int                gap_max = 0;
    bit                force_stall = 1'b0;
    bit                mon_en = 1'b0;
    result_t           exp_q[$];
    logic [DATA_W-1:0] beat_q[$];

    always #5 clk = ~clk;

    parity_stream_accum #(
        .DATA_W(DATA_W), .LANES(LANES), .PIPE_STAGES(PIPE_STAGES), .BEAT_W(BEAT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .cfg_odd(cfg_odd),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_exp(in_exp), .out_valid(out_valid),
        .out_ready(out_ready), .out_par(out_par), .out_err(out_err),
        .out_beats(out_beats)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Every cycle a result is shown it must equal the oldest outstanding packet.
    initial begin
        forever begin
            @(negedge clk);
            out_ready = !force_stall && ($urandom_range(99) < ready_pct);
            #2;
            if (mon_en && rst_n && out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 32'(out_valid), 0);
                end else begin
                    check("mon_par", 32'(out_par), 32'(exp_q[0].par));
                    check("mon_err", 32'(out_err), 32'(exp_q[0].err));
                    check("mon_beats", 32'(out_beats), exp_q[0].beats);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_beat(input logic [DATA_W-1:0] d, input logic last,
                             input logic odd, input logic [LANES-1:0] e);
        bit done = 1'b0;
        int budget = 0;
        repeat ($urandom_range(gap_max)) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = last; cfg_odd = odd; in_exp = e;
        while (!done) begin
            #1;
            done = in_ready;
            @(posedge clk);
            if (!done) begin
                budget++;
                if (budget > 200) begin
                    check("in_ready_timeout", 32'(in_ready), 1);
                    done = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // odd_sel: 0/1 fixed parity sense, 2 = random per beat (only the last beat's counts).
    task automatic send_pkt(input logic [LANES-1:0] e, input int odd_sel, input bit with_last);
        int                ones [LANES];
        int                n;
        logic              odd;
        logic [DATA_W-1:0] d;
        result_t           r;
        n = beat_q.size();
        odd = 1'b0;
        for (int k = 0; k < LANES; k++) ones[k] = 0;
        for (int b = 0; b < n; b++) begin
            d = beat_q[b];
            odd = (odd_sel == 2) ? 1'($urandom_range(1)) : 1'(odd_sel);
            for (int k = 0; k < LANES; k++) ones[k] += $countones(d[k*LW +: LW]);
            send_beat(d, with_last && (b == n - 1), odd, e);
        end
        if (with_last) begin
            for (int k = 0; k < LANES; k++) r.par[LANES-1-k] = ((ones[k] % 2) != 0) ^ odd;
            r.err   = |(r.par ^ e);
            r.beats = (n > BMAX) ? BMAX : n;
            exp_q.push_back(r);
        end
        beat_q.delete();
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue", exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic expect_next(input string tag, input logic [LANES-1:0] p,
                               input logic e, input int b);
        int n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (!out_valid && n < 50);
        check({tag, "_valid"}, 32'(out_valid), 1);
        check({tag, "_par"}, 32'(out_par), 32'(p));
        check({tag, "_err"}, 32'(out_err), 32'(e));
        check({tag, "_beats"}, 32'(out_beats), b);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_par"}, 32'(out_par), 0);
        check({tag, "_out_err"}, 32'(out_err), 0);
        check({tag, "_out_beats"}, 32'(out_beats), 0);
    endtask

    initial begin
        // Reset and idle
        repeat (5) @(negedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #2;
        check("idle_in_ready", 32'(in_ready), 1);
        check("idle_out_valid", 32'(out_valid), 0);
        mon_en = 1'b1;

        // Single beat and its latency
        beat_q = '{16'h0301};
        send_pkt(2'b10, 0, 1'b1);
        @(negedge clk); #2;
        check("lat_t1_valid", 32'(out_valid), 0);
        @(negedge clk); #2;
        check("lat_t2_valid", 32'(out_valid), 1);
        check("single_par", 32'(out_par), 32'(2'b10));
        check("single_err", 32'(out_err), 0);
        check("single_beats", 32'(out_beats), 1);
        drain();

        // Three beats, odd parity, matching then mismatching expectation
        beat_q = '{16'hFFFF, 16'h0001, 16'h0100};
        send_pkt(2'b00, 1, 1'b1);
        expect_next("three_ok", 2'b00, 1'b0, 3);
        drain();
        beat_q = '{16'hFFFF, 16'h0001, 16'h0100};
        send_pkt(2'b01, 1, 1'b1);
        expect_next("three_err", 2'b00, 1'b1, 3);
        drain();

        // Backpressure with a second packet already in the pipeline
        force_stall = 1'b1;
        fork
            begin
                beat_q = '{16'h0001};
                send_pkt(2'b00, 0, 1'b1);
                beat_q = '{16'h0100};
                send_pkt(2'b00, 0, 1'b1);
            end
            begin
                int n = 0;
                do begin
                    @(negedge clk); #2; n++;
                end while (!out_valid && n < 50);
                check("bp_first_valid", 32'(out_valid), 1);
                for (int i = 0; i < 4; i++) begin
                    if (i > 0) begin @(negedge clk); #2; end
                    check("bp_in_ready", 32'(in_ready), 0);
                end
                force_stall = 1'b0;
                @(negedge clk);
                @(negedge clk); #3;
                check("bp_b2b_valid", 32'(out_valid), 1);
            end
        join
        drain();

        // Flush after two beats; a beat presented with flush is dropped
        beat_q = '{16'h0001, 16'h0100};
        send_pkt(2'b00, 0, 1'b0);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_data = 16'h0001; in_last = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        beat_q = '{16'h0003};
        send_pkt(2'b00, 0, 1'b1);
        expect_next("flush", 2'b00, 1'b0, 1);
        drain();

        // Beat counter saturation
        beat_q = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001};
        send_pkt(2'b10, 0, 1'b1);
        expect_next("sat", 2'b10, 1'b0, BMAX);
        drain();

        // Reset pulse mid-packet
        beat_q = '{16'h0001, 16'h0100};
        send_pkt(2'b00, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #2;
            check("midrst_no_valid", 32'(out_valid), 0);
        end
        check("midrst_in_ready", 32'(in_ready), 1);
        beat_q = '{16'h0003};
        send_pkt(2'b11, 1, 1'b1);
        expect_next("midrst_next", 2'b11, 1'b0, 1);
        drain();

        // Randomized traffic with random backpressure
        ready_pct = 60;
        gap_max = 2;
        for (int p = 0; p < 40; p++) begin
            int nb = $urandom_range(1, 6);
            for (int b = 0; b < nb; b++) beat_q.push_back(DATA_W'($urandom));
            send_pkt(LANES'($urandom), 2, 1'b1);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
